fmap_feeder: RTL and testbench
==============================

# fmap_feeder

Streams a stored feature map into the convolution pipeline's pixel input (`din`/`valid_in`/`repeat_in`) in raster order, S×S pixels per pass. It reads an interior (S-2)×(S-2) map from a synchronous-read frame memory and inserts the zero border on the fly. It replays the whole map for a programmable number of passes, with `repeat_in` marking the replays. It sits between the frame buffer and the convolution block and is the only driver of that block's input.

## Interface
- M, 8, pixel width
- S, 482, padded map side (interior side S-2)
- AW, 18, memory address width, ≥ clog2(S*S)
- clk  in  1  clock, all logic on rising edge
- Rst  in  1  asynchronous, active-high reset
- start  in  1  begin streaming; sampled only in IDLE
- n_pass  in  8  pass count, latched on start; 0 treated as 1
- hold  in  1  consumer stall; suppresses new pixel issue
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  AW  memory read address
- mem_rdata  in  M  read data, valid one cycle after mem_rd_en
- din  out  M  pixel to convolution
- valid_in  out  1  din valid
- repeat_in  out  1  pixel belongs to pass ≥ 2; only meaningful with valid_in
- busy  out  1  streaming in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, STREAM, FLUSH.
- IDLE: start=1 latches n_pass (0→1), clears x, y and pass counters, and moves to STREAM.
- STREAM issue cycle, hold=0: issue pixel (x,y).
  - Border pixel (x or y equal to 0 or S-1): no read; a zero is queued.
  - Interior pixel: mem_rd_en=1, mem_addr=(y-1)*(S-2)+(x-1).
  - x advances; at x=S-1 it wraps to 0 and y increments. At (S-1,S-1), y wraps and pass increments.
  - The final pixel of the final pass moves the state to FLUSH.
- hold=1: no issue, all counters frozen, mem_rd_en=0. A pixel issued in the previous cycle still emerges.
- Output stage, one register deep: valid_in=1 exactly one cycle after each issue.
  - din = mem_rdata for interior pixels, 0 for border pixels.
  - repeat_in = (pass of that pixel ≥ 1, zero-based).
- FLUSH: emits the last pixel with done=1 in the same cycle, then returns to IDLE.
- start is ignored while busy. Reset mid-stream aborts immediately with no done pulse.
- Address arithmetic uses an incrementing row-base register (add S-2 per interior row), not a multiplier.

## Timing
- Reset values: mem_rd_en=0, mem_addr=0, din=0, valid_in=0, repeat_in=0, busy=0, done=0. State=IDLE, all counters 0.
- Start accepted at edge k: first issue at cycle k+1, first valid_in at cycle k+2.
- Latency from issue to valid_in: exactly 1 cycle, independent of hold.
- Without hold, one pass produces S*S consecutive valid_in cycles. Passes run back to back with no gap.
- busy=1 from cycle k+1 through the FLUSH cycle inclusive. A new start is accepted in the cycle after done.
- Total without hold: n_pass*S*S valid cycles; done coincides with the last one.

## Configuration
- FMAP_FEEDER_PAD_EN defined: behaviour as above, with the memory holding (S-2)² interior pixels.
- Not defined: no border synthesis. Every pixel is read from mem_addr = y*S+x, so the memory holds the pre-padded S² map. din always equals mem_rdata.
- Timing, states and pass handling are identical in both builds.

## Structure
- Package fmap_feeder_pkg:
  - state enum {IDLE, STREAM, FLUSH}
  - default M, S, AW constants
  - a clog2 function for AW derivation
- One sub-module, raster_counter:
  - x/y/pass counters with enable
  - outputs for wrap, last-pixel and border flags
- The top level holds the FSM, the address generator and the output register.

## Test plan
- S=6, n_pass=1, padding on, memory holds 1..16 → 36 valid_in cycles. Row 0, row 5, column 0 and column 5 are 0; row 1 reads 0,1,2,3,4,0. done pulses on valid cycle 36; repeat_in always 0.
- Same setup with n_pass=3 → 108 contiguous valid cycles. repeat_in=0 for the first 36 and 1 for the remaining 72; single done pulse.
- n_pass=0 → behaves exactly as n_pass=1.
- hold high for cycles 5–9 after the first issue → valid_in drops for exactly 5 cycles one cycle later. Pixel sequence unchanged; done delayed by 5.
- Rst asserted at pixel 20 of pass 2 → all outputs 0 in the same cycle, no done. A subsequent start restarts at pixel (0,0) with repeat_in=0.
- Padding off, S=4, memory holds 0..15 → din sequence 0..15 and mem_addr sequence 0..15. start pulsed while busy → no effect.

Source files
------------

// File: rtl/fmap_feeder_pkg.sv
// Shared types and constants for the feature-map feeder.
// Build option FMAP_FEEDER_PAD_EN (see fmap_feeder.sv) does not affect this package.
package fmap_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam int FM_M   = 8;
    localparam int FM_S   = 482;
    localparam int FM_AW  = 18;
    localparam int PASS_W = 8;

    // Ceiling log2, usable in parameter expressions (value >= 2 expected).
    function automatic int fm_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fmap_feeder_if.sv
// Control, frame-memory and pixel-output signals of the feature-map feeder.
// master: the feeder itself; slave: its environment (memory, sequencer, consumer).
interface fmap_feeder_if #(
    parameter int M  = 8,
    parameter int AW = 18
);
    logic          start;
    logic [7:0]    n_pass;
    logic          hold;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [M-1:0]  mem_rdata;
    logic [M-1:0]  din;
    logic          valid_in;
    logic          repeat_in;
    logic          busy;
    logic          done;

    modport master (
        input  start, n_pass, hold, mem_rdata,
        output mem_rd_en, mem_addr, din, valid_in, repeat_in, busy, done
    );

    modport slave (
        output start, n_pass, hold, mem_rdata,
        input  mem_rd_en, mem_addr, din, valid_in, repeat_in, busy, done
    );

endinterface

// File: rtl/fmap_feeder_raster_counter.sv
// Raster x/y/pass position counter for the feeder, with wrap, last-pixel and border flags.
// Build option FMAP_FEEDER_PAD_EN does not change this module.
module raster_counter
    import fmap_feeder_pkg::*;
#(
    parameter int S  = FM_S,
    parameter int XW = fm_clog2(FM_S)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [PASS_W-1:0] last_pass,
    output logic [XW-1:0]     x,
    output logic [XW-1:0]     y,
    output logic [PASS_W-1:0] pass,
    output logic              x_wrap,
    output logic              last_pix,
    output logic              last_all,
    output logic              border
);

    localparam logic [XW-1:0] EDGE = XW'(S - 1);

    assign x_wrap   = (x == EDGE);
    assign last_pix = x_wrap && (y == EDGE);
    assign last_all = last_pix && (pass == last_pass);
    assign border   = (x == '0) || (y == '0) || x_wrap || (y == EDGE);

    // NOTE: the reset branch sits in the sensitivity list so rst acts without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            pass <= '0;
        end else if (clr) begin
            x    <= '0;
            y    <= '0;
            pass <= '0;
        end else if (en) begin
            // NOTE: non-blocking updates keep every flop reading pre-edge values.
            if (x_wrap) begin
                x <= '0;
                if (y == EDGE) begin
                    y    <= '0;
                    pass <= last_all ? '0 : pass + 1'b1;
                end else begin
                    y <= y + 1'b1;
                end
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmap_feeder.sv
// Streams a stored feature map, S x S pixels per pass, for n_pass passes into the conv input.
// FMAP_FEEDER_PAD_EN: memory holds the (S-2)^2 interior and the zero border is synthesised.
module fmap_feeder
    import fmap_feeder_pkg::*;
#(
    parameter int M  = FM_M,
    parameter int S  = FM_S,
    parameter int AW = FM_AW
) (
    input  logic          clk,
    input  logic          rst,
    fmap_feeder_if.master bus
);

    localparam int XW = fm_clog2(S);
`ifdef FMAP_FEEDER_PAD_EN
    localparam logic [AW-1:0] ROW_STEP = AW'(S - 2);
`else
    localparam logic [AW-1:0] ROW_STEP = AW'(S);
`endif

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              issue;
    logic [PASS_W-1:0] last_pass;
    logic [XW-1:0]     x;
    logic [XW-1:0]     y;
    logic [PASS_W-1:0] pass;
    logic              x_wrap;
    logic              last_pix;
    logic              last_all;
    logic              border;
    logic [AW-1:0]     row_base;
    logic [AW-1:0]     rd_addr;
    logic              rd_en;
    logic              valid_q;
    logic              repeat_q;
    logic              zero_q;
    logic [M-1:0]      din_mux;

    raster_counter #(
        .S  (S),
        .XW (XW)
    ) u_raster (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .en        (issue),
        .last_pass (last_pass),
        .x         (x),
        .y         (y),
        .pass      (pass),
        .x_wrap    (x_wrap),
        .last_pix  (last_pix),
        .last_all  (last_all),
        .border    (border)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (!bus.hold) begin
                    issue = 1'b1;
                    if (last_all) state_nxt = FLUSH;
                end
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A zero pass count runs the map once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_pass <= '0;
        else if (accept) last_pass <= (bus.n_pass == '0) ? '0 : bus.n_pass - 1'b1;
    end

    // Row base advances by one memory row each time a raster row that holds stored pixels ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_base <= '0;
        end else if (accept) begin
            row_base <= '0;
        end else if (issue && x_wrap) begin
            if (last_pix) begin
                row_base <= '0;
`ifdef FMAP_FEEDER_PAD_EN
            end else if (y != '0) begin
                row_base <= row_base + ROW_STEP;
`else
            end else begin
                row_base <= row_base + ROW_STEP;
`endif
            end
        end
    end

`ifdef FMAP_FEEDER_PAD_EN
    assign rd_en   = issue && !border;
    assign rd_addr = row_base + AW'(x) - AW'(1);
`else
    logic unused_pad;
    assign unused_pad = border ^ (|y);
    assign rd_en      = issue;
    assign rd_addr    = row_base + AW'(x);
`endif

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = rd_en ? rd_addr : '0;

    // Output stage: read data lands one cycle after issue, so only the tags are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            repeat_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            valid_q  <= issue;
            repeat_q <= issue && (pass != '0);
            zero_q   <= issue && !rd_en;
        end
    end

    assign din_mux       = (valid_q && !zero_q) ? bus.mem_rdata : '0;
    assign bus.din       = din_mux;
    assign bus.valid_in  = valid_q;
    assign bus.repeat_in = repeat_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FLUSH);

endmodule

// File: tb/tb_fmap_feeder.sv
// Directed bench for fmap_feeder: S=6 with FMAP_FEEDER_PAD_EN, S=4 pre-padded map otherwise.
// Covers single/multi/zero pass counts, hold, mid-stream reset, restart and start while busy.
module tb_fmap_feeder;
    import fmap_feeder_pkg::*;

`ifdef FMAP_FEEDER_PAD_EN
    localparam int S    = 6;
    localparam int NINT = (S - 2) * (S - 2);
`else
    localparam int S    = 4;
    localparam int NINT = S * S;
`endif
    localparam int M    = 8;
    localparam int AW   = fm_clog2(S * S);
    localparam int NPIX = S * S;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   dq[$];
    int   rq[$];
    int   aq[$];
    logic [M-1:0] mem [NPIX];

    fmap_feeder_if #(.M(M), .AW(AW)) bus ();

    fmap_feeder #(.M(M), .S(S), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_pix(input int i);
        int x;
        int y;
        x = i % S;
        y = i / S;
`ifdef FMAP_FEEDER_PAD_EN
        if (x == 0 || y == 0 || x == S - 1 || y == S - 1) return 0;
        return (y - 1) * (S - 2) + (x - 1) + 1;
`else
        return y * S + x;
`endif
    endfunction

    function automatic int all_outs();
        return int'({bus.mem_rd_en, bus.mem_addr, bus.din, bus.valid_in,
                     bus.repeat_in, bus.busy, bus.done});
    endfunction

    // One start-to-done run; c counts cycles after the accepting edge (c=0 is the first issue).
    task automatic run(input string name, input int np, input int hold_from, input int hold_len,
                       input int abort_at, input bit poke_start);
        int np_eff, first_v, last_v, done_c, done_cnt, busy_bad, budget;
        bit finished, aborted;
        dq.delete();
        rq.delete();
        aq.delete();
        np_eff   = (np == 0) ? 1 : np;
        first_v  = -1;
        last_v   = -1;
        done_c   = -1;
        done_cnt = 0;
        busy_bad = 0;
        finished = 0;
        aborted  = 0;
        budget   = np_eff * NPIX + hold_len + 20;
        @(negedge clk);
        bus.n_pass = 8'(np);
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 0; c < budget && !finished && !aborted; c++) begin
            if (hold_len > 0 && c == hold_from) bus.hold = 1'b1;
            if (hold_len > 0 && c == hold_from + hold_len) bus.hold = 1'b0;
            if (poke_start && c == 10) begin
                bus.start  = 1'b1;
                bus.n_pass = 8'd5;
            end
            if (poke_start && c == 11) bus.start = 1'b0;
            @(negedge clk);
            if (!bus.busy) busy_bad++;
            if (bus.mem_rd_en) aq.push_back(int'(bus.mem_addr));
            if (bus.valid_in) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                dq.push_back(int'(bus.din));
                rq.push_back(int'(bus.repeat_in));
            end
            if (bus.done) begin
                done_cnt++;
                done_c   = c;
                finished = 1'b1;
            end
            if (abort_at > 0 && dq.size() == abort_at) begin
                check({name, ":abort_rep"}, rq[abort_at-1], 1);
                rst = 1'b1;
                #1 check({name, ":rst_outs"}, all_outs(), 0);
                aborted = 1'b1;
            end
            if (!finished && !aborted) begin
                @(posedge clk);
                #1;
            end
        end
        if (aborted) begin
            check({name, ":abort_nodone"}, done_cnt, 0);
            repeat (2) begin
                @(negedge clk);
                check({name, ":rst_hold_outs"}, all_outs(), 0);
            end
            rst = 1'b0;
            bus.hold = 1'b0;
            return;
        end
        check({name, ":done_seen"}, int'(finished), 1);
        check({name, ":n_valid"}, dq.size(), np_eff * NPIX);
        check({name, ":first_valid"}, first_v, 1);
        check({name, ":span"}, last_v - first_v + 1, np_eff * NPIX + hold_len);
        check({name, ":done_cycle"}, done_c, np_eff * NPIX + hold_len);
        check({name, ":done_on_last"}, done_c, last_v);
        check({name, ":done_count"}, done_cnt, 1);
        check({name, ":busy_gaps"}, busy_bad, 0);
        check({name, ":n_reads"}, aq.size(), np_eff * NINT);
        for (int i = 0; i < aq.size() && i < np_eff * NINT; i++)
            check($sformatf("%s:addr%0d", name, i), aq[i], i % NINT);
        for (int i = 0; i < dq.size() && i < np_eff * NPIX; i++)
            check($sformatf("%s:pix%0d", name, i), (rq[i] << 8) | dq[i],
                  ((i >= NPIX ? 1 : 0) << 8) | exp_pix(i % NPIX));
        @(negedge clk);
        check({name, ":idle_after"}, all_outs(), 0);
        bus.hold = 1'b0;
    endtask

    initial begin
        int row1[6];
        bus.start  = 1'b0;
        bus.n_pass = 8'd0;
        bus.hold   = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
`ifdef FMAP_FEEDER_PAD_EN
            mem[i] = (i < NINT) ? M'(i + 1) : '0;
`else
            mem[i] = M'(i);
`endif
        end
        #3 check("reset_outs", all_outs(), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", all_outs(), 0);

        run("pass1", 1, 0, 0, 0, 1'b0);
`ifdef FMAP_FEEDER_PAD_EN
        row1 = '{0, 1, 2, 3, 4, 0};
        for (int j = 0; j < 6; j++)
            if (dq.size() > 6 + j) check($sformatf("row1_%0d", j), dq[6+j], row1[j]);
            else                   check($sformatf("row1_%0d", j), -1, row1[j]);
`else
        row1 = '{0, 1, 2, 3, 4, 5};
        for (int j = 0; j < 6; j++)
            if (dq.size() > j) check($sformatf("raw_%0d", j), dq[j], row1[j]);
            else               check($sformatf("raw_%0d", j), -1, row1[j]);
`endif
        run("pass3", 3, 0, 0, 0, 1'b0);
        run("pass0_poke", 0, 0, 0, 0, 1'b1);
        run("hold", 1, 5, 5, 0, 1'b0);
        run("abort", 3, 0, 0, NPIX + 20, 1'b0);
        run("restart", 1, 0, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
